// File: rtl/seg7_scan_capture.sv
// Rebuilds four hex digits from a scanned, active-low 7-segment an/seg bus.
// Optional stale-digit timeout is compiled in with `define SEG7_CAPTURE_STALE_EN.
module seg7_scan_capture #(
  parameter int SETTLE_CYCLES = 8,
  parameter int CONFIRM       = 2,
  parameter int TIMEOUT       = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SETTLING, SAMPLED} state_t;

  logic [3:0]  an_s1_reg, an_s2_reg;
  logic [6:0]  seg_s1_reg, seg_s2_reg;
  logic [10:0] last_reg;
  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        take_sample;
  logic        changed, an_blank;
  logic        an_legal;
  logic [1:0]  an_idx;
  logic        seg_ok, seg_blank;
  logic [3:0]  seg_val;
  logic [3:0]  mask_reg, mask_set;
  logic [3:0]  stale_vec;
  logic        err_reg, frame_done_reg;

  // Synchronizers idle at the blank-display level so reset never looks like a dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_reg  <= 4'hF;
      an_s2_reg  <= 4'hF;
      seg_s1_reg <= 7'h7F;
      seg_s2_reg <= 7'h7F;
      last_reg   <= {4'hF, 7'h7F};
    end else begin
      an_s1_reg  <= an;
      an_s2_reg  <= an_s1_reg;
      seg_s1_reg <= seg;
      seg_s2_reg <= seg_s1_reg;
      last_reg   <= {an_s2_reg, seg_s2_reg};
    end
  end

  assign changed  = ({an_s2_reg, seg_s2_reg} != last_reg);
  assign an_blank = (an_s2_reg == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    take_sample = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!an_blank) begin
          state_next = SETTLING;
          cnt_next   = '0;
        end
      end
      SETTLING: begin
        if (changed) begin
          cnt_next   = '0;
          state_next = an_blank ? IDLE : SETTLING;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_reg == 8'(SETTLE_CYCLES - 2)) begin
            take_sample = 1'b1;
            state_next  = SAMPLED;
          end
        end
      end
      SAMPLED: begin
        if (changed) begin
          cnt_next   = '0;
          state_next = an_blank ? IDLE : SETTLING;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    an_legal = 1'b1;
    an_idx   = 2'd0;
    case (an_s2_reg)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_legal = 1'b0;
    endcase
  end

  assign seg_blank = (seg_s2_reg == 7'h7F);

  always_comb begin
    seg_ok  = 1'b1;
    seg_val = 4'h0;
    case (seg_s2_reg)
      7'h40: seg_val = 4'h0;
      7'h79: seg_val = 4'h1;
      7'h24: seg_val = 4'h2;
      7'h30: seg_val = 4'h3;
      7'h19: seg_val = 4'h4;
      7'h12: seg_val = 4'h5;
      7'h02: seg_val = 4'h6;
      7'h78: seg_val = 4'h7;
      7'h00: seg_val = 4'h8;
      7'h10: seg_val = 4'h9;
      7'h08: seg_val = 4'hA;
      7'h03: seg_val = 4'hB;
      7'h46: seg_val = 4'hC;
      7'h21: seg_val = 4'hD;
      7'h06: seg_val = 4'hE;
      7'h0E: seg_val = 4'hF;
      default: seg_ok = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0] cand_reg, nib_reg;
    logic [2:0] conf_reg, conf_new;
    logic       valid_reg;
    logic       hit;
    logic       stale;

    assign hit = take_sample && an_legal && (an_idx == 2'(gi));

    always_comb begin
      conf_new = 3'd1;
      if (seg_val == cand_reg)
        conf_new = (conf_reg >= 3'(CONFIRM)) ? 3'(CONFIRM) : conf_reg + 3'd1;
    end

`ifdef SEG7_CAPTURE_STALE_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] stale_cnt_reg;

    // Saturates at TIMEOUT so a dead digit reports stale only once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stale_cnt_reg <= '0;
      else if (hit)
        stale_cnt_reg <= '0;
      else if (stale_cnt_reg != TW'(TIMEOUT))
        stale_cnt_reg <= stale_cnt_reg + 1'b1;
    end
    assign stale = !hit && (stale_cnt_reg == TW'(TIMEOUT - 1));
`else
    assign stale = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand_reg  <= '0;
        conf_reg  <= '0;
        nib_reg   <= '0;
        valid_reg <= 1'b0;
      end else if (hit) begin
        if (seg_blank) begin
          valid_reg <= 1'b0;
        end else if (seg_ok) begin
          cand_reg <= seg_val;
          conf_reg <= conf_new;
          if (conf_new == 3'(CONFIRM)) begin
            nib_reg   <= seg_val;
            valid_reg <= 1'b1;
          end
        end else begin
          valid_reg <= 1'b0;
          conf_reg  <= '0;
        end
      end else if (stale) begin
        valid_reg <= 1'b0;
      end
    end

    assign digits[4*gi +: 4] = nib_reg;
    assign digit_valid[gi]   = valid_reg;
    assign stale_vec[gi]     = stale;
  end

`ifndef SEG7_CAPTURE_STALE_EN
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign mask_set = mask_reg | (4'b0001 << an_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg       <= '0;
      err_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      err_reg        <= (take_sample && (!an_legal || (!seg_ok && !seg_blank))) || (|stale_vec);
      frame_done_reg <= 1'b0;
      if (take_sample && an_legal) begin
        if (mask_set == 4'hF) begin
          frame_done_reg <= 1'b1;
          mask_reg       <= '0;
        end else begin
          mask_reg <= mask_set;
        end
      end
    end
  end

  assign err        = err_reg;
  assign frame_done = frame_done_reg;

endmodule
